// File: rtl/beam_delay_scheduler.sv
// Receive-beamforming delay scheduler: fetches per-channel focus delays into a shadow bank and commits it atomically.
// Optional build macro CHANNEL_MASK_EN adds chan_mask to skip and zero selected channels.
module beam_delay_scheduler #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 16,
    parameter int MAX_DELAY    = 256,
    parameter int DELAY_WIDTH  = $clog2(MAX_DELAY),
    parameter int CALC_WIDTH   = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [15:0]                        x_f,
    input  logic [15:0]                        z_f,
    output logic                               busy,
    output logic                               ready,
    output logic                               table_valid,
    output logic                               clamp_flag,
    output logic                               calc_req,
    output logic [$clog2(NUM_CHANNELS)-1:0]    calc_ch,
    output logic [15:0]                        calc_x_f,
    output logic [15:0]                        calc_z_f,
    input  logic                               calc_ack,
    input  logic [CALC_WIDTH-1:0]              calc_delay,
`ifdef CHANNEL_MASK_EN
    input  logic [NUM_CHANNELS-1:0]            chan_mask,
`endif
    input  logic                               din_valid,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] din_flat,
    output logic                               dout_valid,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] delayed_flat
);

    localparam int CH_W = $clog2(NUM_CHANNELS);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WRITE,
        S_NEXT,
        S_COMMIT
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CH_W-1:0]         ch;
    logic [CH_W-1:0]         ch_inc;
    logic [CALC_WIDTH-1:0]   cap_delay;
    logic                    active;
    logic [DELAY_WIDTH-1:0]  bank0 [NUM_CHANNELS];
    logic [DELAY_WIDTH-1:0]  bank1 [NUM_CHANNELS];
    logic [DELAY_WIDTH-1:0]  wp;
    logic [NUM_CHANNELS-1:0] mask;

`ifdef CHANNEL_MASK_EN
    assign mask = chan_mask;
`else
    assign mask = '0;
`endif

    function automatic logic is_clamped(input logic [CALC_WIDTH-1:0] v);
        return v > CALC_WIDTH'(MAX_DELAY - 1);
    endfunction

    function automatic logic [DELAY_WIDTH-1:0] sat_delay(input logic [CALC_WIDTH-1:0] v);
        if (is_clamped(v)) return DELAY_WIDTH'(MAX_DELAY - 1);
        return v[DELAY_WIDTH-1:0];
    endfunction

    assign ch_inc  = ch + 1'b1;
    assign calc_ch = ch;

    always_comb begin
        state_nxt = state;
        calc_req  = 1'b0;
        ready     = 1'b0;
        busy      = (state != S_IDLE);
        unique case (state)
            S_IDLE:   if (start) state_nxt = mask[0] ? S_WRITE : S_REQ;
            S_REQ: begin
                calc_req  = 1'b1;
                state_nxt = calc_ack ? S_WRITE : S_WAIT;
            end
            S_WAIT: begin
                calc_req = 1'b1;
                if (calc_ack) state_nxt = S_WRITE;
            end
            S_WRITE:  state_nxt = S_NEXT;
            S_NEXT: begin
                if (ch == LAST_CH) state_nxt = S_COMMIT;
                else               state_nxt = mask[ch_inc] ? S_WRITE : S_REQ;
            end
            S_COMMIT: begin
                ready     = 1'b1;
                state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Control: FSM state, focus latch, shadow-bank writes, commit. Skipped channels keep cap_delay at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            ch          <= '0;
            cap_delay   <= '0;
            calc_x_f    <= '0;
            calc_z_f    <= '0;
            clamp_flag  <= 1'b0;
            table_valid <= 1'b0;
            active      <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        calc_x_f   <= x_f;
                        calc_z_f   <= z_f;
                        clamp_flag <= 1'b0;
                        ch         <= '0;
                        cap_delay  <= '0;
                    end
                end
                S_REQ, S_WAIT: begin
                    if (calc_ack) cap_delay <= calc_delay;
                end
                S_WRITE: begin
                    if (active) bank0[ch] <= sat_delay(cap_delay);
                    else        bank1[ch] <= sat_delay(cap_delay);
                    if (is_clamped(cap_delay)) clamp_flag <= 1'b1;
                end
                S_NEXT: begin
                    if (ch != LAST_CH) begin
                        ch        <= ch_inc;
                        cap_delay <= '0;
                    end
                end
                S_COMMIT: begin
                    active      <= ~active;
                    table_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp         <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= din_valid;
            if (din_valid) wp <= wp + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_line
        logic [DATA_WIDTH-1:0]  ram [MAX_DELAY];
        logic [DATA_WIDTH-1:0]  din_p0;
        logic [DELAY_WIDTH-1:0] d_p0;
        logic [DELAY_WIDTH-1:0] raddr_p0;
        logic [DATA_WIDTH-1:0]  dout_p1;

        assign din_p0   = din_flat[g*DATA_WIDTH +: DATA_WIDTH];
        assign d_p0     = active ? bank1[g] : bank0[g];
        assign raddr_p0 = wp - d_p0;

        always_ff @(posedge clk) begin
            if (din_valid) ram[wp] <= din_p0;
        end

        // Stage p0 -> p1: zero delay bypasses the RAM so the current sample comes straight through.
        always_ff @(posedge clk or posedge reset) begin
            if (reset)          dout_p1 <= '0;
            else if (din_valid) dout_p1 <= (d_p0 == '0) ? din_p0 : ram[raddr_p0];
        end

        assign delayed_flat[g*DATA_WIDTH +: DATA_WIDTH] = mask[g] ? '0 : dout_p1;
    end

endmodule

// File: doc/beam_delay_scheduler.md
Name: beam_delay_scheduler

Overview:
- Parametrised successor to the channel delay controller for receive beamforming.
- Fetches per-channel focusing delays from an external delay calculator over a req/ack handshake and writes them into a shadow delay table.
- Commits the shadow table atomically (double-buffered), so the next focal point is computed while the current focus keeps steering the per-channel sample delay lines.
- Sits between the ADC sample stream and the summation stage.

Parameters:
- DATA_WIDTH, 16, sample width per channel
- NUM_CHANNELS, 16, channel count (≥2)
- MAX_DELAY, 256, delay-line depth in samples; power of 2
- DELAY_WIDTH, $clog2(MAX_DELAY), width of stored delay
- CALC_WIDTH, 16, width of returned calc_delay

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request new focus; accepted only when busy=0
- x_f  in  16  focal x, latched on accepted start
- z_f  in  16  focal z, latched on accepted start
- busy  out  1  table update in progress
- ready  out  1  one-cycle pulse at commit
- table_valid  out  1  sticky: at least one commit since reset
- clamp_flag  out  1  sticky per update: some delay saturated
- calc_req  out  1  request to delay calculator
- calc_ch  out  $clog2(NUM_CHANNELS)  channel index of request
- calc_x_f  out  16  latched focal x
- calc_z_f  out  16  latched focal z
- calc_ack  in  1  calculator result valid
- calc_delay  in  CALC_WIDTH  delay in samples (unsigned)
- din_valid  in  1  sample strobe for all channels
- din_flat  in  NUM_CHANNELS*DATA_WIDTH  channel i at bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
- dout_valid  out  1  din_valid delayed 1 cycle
- delayed_flat  out  NUM_CHANNELS*DATA_WIDTH  delayed samples, same packing

Behaviour:
- Reset (async): all outputs 0; FSM IDLE; both table banks all-zero; active bank 0; write pointer 0; delay-line contents are don't-care but dout forced 0 until the first dout_valid.
- FSM states and transitions:
  - IDLE: start → latch x_f/z_f, clear clamp_flag, ch=0 → REQ.
  - REQ: calc_req=1 → WAIT.
  - WAIT: calc_req held high, calc_ch stable, until calc_ack → WRITE. An ack arriving in the same cycle as req rise is valid.
  - WRITE: shadow[ch] ← min(calc_delay, MAX_DELAY-1); set clamp_flag if clamped → NEXT.
  - NEXT: ch==NUM_CHANNELS-1 → COMMIT, else ch+1 → REQ.
  - COMMIT: toggle active bank; ready=1 for this cycle; table_valid←1 → IDLE.
- calc_req deasserts the cycle after ack. calc_ack outside WAIT is ignored.
- busy=1 in every state except IDLE. start while busy is ignored; the latched focus is unchanged.
- Delay lines: one shared write pointer wp of DELAY_WIDTH bits, wrapping MAX_DELAY-1→0, advanced on din_valid.
  - On din_valid, each channel writes din at wp and registers the output.
  - Output is mem[wp - d] (modulo MAX_DELAY), where d is the active-bank delay. d=0 bypasses to the current din.
  - Latency 1 cycle; dout_valid = din_valid registered. delayed_flat holds its value when din_valid=0.
- The bank swap takes effect on the first din_valid after the COMMIT cycle. A din_valid in the COMMIT cycle itself uses the old bank.
- Samples older than written history read stale memory; no masking.
- Reset mid-update aborts it; both banks return to zero.

Optional Feature:
- Macro CHANNEL_MASK_EN.
- Defined:
  - Adds input chan_mask [NUM_CHANNELS-1:0].
  - Masked channels skip REQ/WAIT: the shadow entry is written 0 directly in WRITE.
  - Masked channels output 0 on delayed_flat; mask is sampled every cycle.
- Undefined: no port; all channels active.

Test Plan:
- Reset, then 20 din_valid pulses with ramp data, no start → each channel's output equals its input one cycle later (delay 0); table_valid=0.
- start with x_f=0x0100, z_f=0x0400; calculator returns delay=3·ch with 2-cycle ack latency → ready pulses once after 16 handshakes; channel 5 output equals the input 15 samples earlier; busy=0 afterwards.
- Calculator returns 300 for ch 2 with MAX_DELAY=256 → stored delay 255; clamp_flag=1; other channels are unaffected.
- Continuous din_valid while a second start (delays 2·ch) runs → outputs follow the old delays through COMMIT, then the new delays from the next sample; start pulsed mid-update is ignored.
- Assert reset during WAIT at ch=7 → calc_req drops immediately; busy=0; outputs use delay 0.
- With CHANNEL_MASK_EN and mask 0x0003 → only 14 handshakes occur; channels 0 and 1 output 0.
